morse_message_sequencer: RTL and testbench

- Queues up to DEPTH Morse letters (codes A–H) and plays them back-to-back with standard unit timing.
- Per letter, drives a mark/space output plus a one-hot element-position LED bus.
- Owns the sequencing of the Morse display path: letter lookup, element timing, inter-element and inter-letter gaps, queue arbitration between the producer and playback.

---
 rtl/morse_message_sequencer.sv | 141 ++++++++++++++
 tb/tb_morse_message_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_message_sequencer.sv
// Morse letter sequencer: queues codes A-H and plays them with unit timing,
// driving a mark/space line and a one-hot element-position LED bus.
module morse_message_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int DEPTH    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    push,
    input  logic [2:0]              letter,
    output logic                    ready,
    input  logic                    abort,
    output logic                    mark,
    output logic [3:0]              LEDR,
    output logic                    busy,
    output logic                    letter_done,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MARK, S_SPACE, S_GAP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   presc;
    logic [1:0]      units, units_last;
    logic [1:0]      elem, elem_nxt;
    logic [1:0]      last_elem;
    logic [3:0]      dash_mask;
    logic            tick, expire, push_ok, pop;
    logic            mark_d, busy_d, done_d;
    logic [3:0]      ledr_d;

    // {index of last element, dash mask with bit i = element i}
    function automatic logic [5:0] pattern(input logic [2:0] code);
        case (code)
            3'd0:    pattern = {2'd1, 4'b0010};  // A .-
            3'd1:    pattern = {2'd3, 4'b0001};  // B -...
            3'd2:    pattern = {2'd3, 4'b0101};  // C -.-.
            3'd3:    pattern = {2'd2, 4'b0001};  // D -..
            3'd4:    pattern = {2'd0, 4'b0000};  // E .
            3'd5:    pattern = {2'd3, 4'b0100};  // F ..-.
            3'd6:    pattern = {2'd2, 4'b0011};  // G --.
            default: pattern = {2'd3, 4'b0000};  // H ....
        endcase
    endfunction

    // LOAD frees the head slot in the same cycle, so a full queue may still accept there
    assign ready   = (count < CW'(DEPTH)) || (state == S_LOAD);
    assign push_ok = push && ready && !abort;
    assign pop     = (state == S_LOAD) && !abort;

    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign units_last = ((state == S_GAP) || ((state == S_MARK) && dash_mask[elem])) ? 2'd2 : 2'd0;
    assign expire     = tick && (units == units_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (count != '0) state_nxt = S_LOAD;
                S_LOAD: begin
                    state_nxt = S_MARK;
                    elem_nxt  = 2'd0;
                end
                S_MARK:  if (expire) state_nxt = (elem == last_elem) ? S_GAP : S_SPACE;
                S_SPACE: if (expire) begin
                    state_nxt = S_MARK;
                    elem_nxt  = elem + 2'd1;
                end
                S_GAP:   if (expire) state_nxt = (count != '0) ? S_LOAD : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered on state entry
    always_comb begin
        mark_d = (state_nxt == S_MARK);
        ledr_d = mark_d ? (4'b1000 >> elem_nxt) : 4'b0000;
        busy_d = (state_nxt != S_IDLE);
        done_d = (state == S_GAP) && expire && !abort;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mark        <= 1'b0;
            LEDR        <= 4'b0000;
            busy        <= 1'b0;
            letter_done <= 1'b0;
            elem        <= 2'd0;
            presc       <= '0;
            units       <= 2'd0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            mark        <= mark_d;
            LEDR        <= ledr_d;
            busy        <= busy_d;
            letter_done <= done_d;
            elem        <= elem_nxt;
            if (abort || (state_nxt != state)) begin
                presc <= '0;
                units <= 2'd0;
            end else if (tick) begin
                presc <= '0;
                units <= units + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (abort) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count + CW'(push_ok) - CW'(pop);
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Queue storage and latched letter pattern carry no reset
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= letter;
        if (pop)     {last_elem, dash_mask} <= pattern(mem[rd_ptr]);
    end

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Directed bench for morse_message_sequencer: one instance at TICK_DIV=2, one at TICK_DIV=1.
module tb_morse_message_sequencer;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst2 = 1'b1, push2 = 1'b0, abort2 = 1'b0;
    logic [2:0] letter2 = 3'd0;
    logic       ready2, mark2, busy2, done2;
    logic [3:0] ledr2;
    logic [2:0] count2;

    logic       rst1 = 1'b1, push1 = 1'b0, abort1 = 1'b0;
    logic [2:0] letter1 = 3'd0;
    logic       ready1, mark1, busy1, done1;
    logic [3:0] ledr1;
    logic [2:0] count1;

    morse_message_sequencer #(.TICK_DIV(2), .DEPTH(4)) dut2 (
        .CLK(CLK), .RST(rst2), .push(push2), .letter(letter2), .ready(ready2),
        .abort(abort2), .mark(mark2), .LEDR(ledr2), .busy(busy2),
        .letter_done(done2), .count(count2)
    );

    morse_message_sequencer #(.TICK_DIV(1), .DEPTH(4)) dut1 (
        .CLK(CLK), .RST(rst1), .push(push1), .letter(letter1), .ready(ready1),
        .abort(abort1), .mark(mark1), .LEDR(ledr1), .busy(busy1),
        .letter_done(done1), .count(count1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle trace: {count[2:0], done, busy, mark, ledr[3:0]}
    logic       rec = 1'b0;
    logic       sel1 = 1'b0;
    logic [9:0] tr[$];

    task automatic step();
        @(posedge CLK);
        #1;
        if (rec) begin
            if (sel1) tr.push_back({count1, done1, busy1, mark1, ledr1});
            else      tr.push_back({count2, done2, busy2, mark2, ledr2});
        end
    endtask

    task automatic start_rec(input logic s);
        tr.delete();
        sel1 = s;
        rec  = 1'b1;
    endtask

    int         runs_m[$], runs_s[$], exp_m[$], exp_s[$];
    logic [3:0] leds_m[$], exp_l[$];
    int         n_done, done_busy, max_cnt, first_mark;

    task automatic analyze();
        int mrun, srun;
        runs_m.delete(); runs_s.delete(); leds_m.delete();
        n_done = 0; done_busy = 0; max_cnt = 0; first_mark = -1;
        mrun = 0; srun = 0;
        foreach (tr[i]) begin
            logic [9:0] t;
            t = tr[i];
            if (t[6]) begin
                n_done++;
                if (t[5]) done_busy++;
            end
            if (int'(t[9:7]) > max_cnt) max_cnt = int'(t[9:7]);
            if (t[4]) begin
                if (mrun == 0) begin
                    leds_m.push_back(t[3:0]);
                    if (first_mark < 0) first_mark = i;
                end
                mrun++;
                if (srun > 0) begin runs_s.push_back(srun); srun = 0; end
            end else begin
                if (mrun > 0) begin runs_m.push_back(mrun); mrun = 0; end
                if (t[5]) srun++;
                else if (srun > 0) begin runs_s.push_back(srun); srun = 0; end
            end
        end
        if (mrun > 0) runs_m.push_back(mrun);
        if (srun > 0) runs_s.push_back(srun);
    endtask

    task automatic cmp_trace(input string tag);
        check({tag, "_nmark"}, runs_m.size(), exp_m.size());
        for (int i = 0; i < exp_m.size() && i < runs_m.size(); i++)
            check($sformatf("%s_mark%0d", tag, i), runs_m[i], exp_m[i]);
        for (int i = 0; i < exp_l.size() && i < leds_m.size(); i++)
            check($sformatf("%s_led%0d", tag, i), int'(leds_m[i]), int'(exp_l[i]));
        check({tag, "_nspace"}, runs_s.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < runs_s.size(); i++)
            check($sformatf("%s_space%0d", tag, i), runs_s[i], exp_s[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        step(); step();
        rst1 = 1'b0; rst2 = 1'b0;
        step();
        check("rst_mark",  int'(mark2), 0);
        check("rst_ledr",  int'(ledr2), 0);
        check("rst_busy",  int'(busy2), 0);
        check("rst_done",  int'(done2), 0);
        check("rst_count", int'(count2), 0);
        check("rst_ready", int'(ready2), 1);
        check("rst_ready1", int'(ready1), 1);

        // E at TICK_DIV=2
        start_rec(1'b0);
        letter2 = 3'd4; push2 = 1'b1;
        step();
        push2 = 1'b0; letter2 = 3'd7;
        repeat (14) step();
        rec = 1'b0;
        analyze();
        exp_m = '{2}; exp_l = '{4'b1000}; exp_s = '{1, 6};
        cmp_trace("E");
        check("E_done", n_done, 1);
        check("E_done_busy", done_busy, 0);
        check("E_latency", first_mark, 2);
        check("E_end_busy", int'(busy2), 0);

        // A at TICK_DIV=2
        start_rec(1'b0);
        letter2 = 3'd0; push2 = 1'b1;
        step();
        push2 = 1'b0;
        repeat (24) step();
        rec = 1'b0;
        analyze();
        exp_m = '{2, 6}; exp_l = '{4'b1000, 4'b0100}; exp_s = '{1, 2, 6};
        cmp_trace("A");
        check("A_done", n_done, 1);

        // B, C, H back-to-back at TICK_DIV=1
        start_rec(1'b1);
        letter1 = 3'd1; push1 = 1'b1; step();
        letter1 = 3'd2; step();
        letter1 = 3'd7; step();
        push1 = 1'b0; letter1 = 3'd4;
        repeat (50) step();
        rec = 1'b0;
        analyze();
        exp_m = '{3, 1, 1, 1, 3, 1, 3, 1, 1, 1, 1, 1};
        exp_l = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100,
                  4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exp_s = '{1, 1, 1, 1, 4, 1, 1, 1, 4, 1, 1, 1, 3};
        cmp_trace("BCH");
        check("BCH_done", n_done, 3);
        check("BCH_maxcnt_le3", int'(max_cnt <= 3), 1);
        check("BCH_maxcnt", max_cnt, 2);

        // Fill the queue while G holds its first dash
        start_rec(1'b0);
        letter2 = 3'd6; push2 = 1'b1;
        step();
        push2 = 1'b0;
        k = 0;
        while (mark2 !== 1'b1 && k < 20) begin step(); k++; end
        check("full_mark_up", int'(mark2), 1);
        for (int i = 0; i < 4; i++) begin
            letter2 = 3'd4; push2 = 1'b1;
            step();
        end
        push2 = 1'b0;
        check("full_count", int'(count2), 4);
        check("full_ready", int'(ready2), 0);
        letter2 = 3'd7; push2 = 1'b1;
        step();
        push2 = 1'b0;
        check("full_drop_count", int'(count2), 4);
        k = 0;
        while (done2 !== 1'b1 && k < 100) begin step(); k++; end
        check("full_load_done", int'(done2), 1);
        check("full_load_count", int'(count2), 4);
        check("full_load_ready", int'(ready2), 1);
        letter2 = 3'd0; push2 = 1'b1;
        step();
        push2 = 1'b0;
        check("full_load_push_count", int'(count2), 4);
        k = 0;
        while (busy2 !== 1'b0 && k < 300) begin step(); k++; end
        check("full_idle", int'(busy2), 0);
        step();
        rec = 1'b0;
        analyze();
        exp_m = '{6, 6, 2, 2, 2, 2, 2, 2, 6};
        exp_l = '{4'b1000, 4'b0100, 4'b0010, 4'b1000, 4'b1000,
                  4'b1000, 4'b1000, 4'b1000, 4'b0100};
        exp_s = '{1, 2, 2, 7, 7, 7, 7, 7, 2, 6};
        cmp_trace("FULL");
        check("FULL_done", n_done, 6);

        // abort in the middle of G's first dash, with a push in the same cycle
        start_rec(1'b0);
        letter2 = 3'd6; push2 = 1'b1;
        step();
        push2 = 1'b0;
        k = 0;
        while (mark2 !== 1'b1 && k < 20) begin step(); k++; end
        check("abort_mark_up", int'(mark2), 1);
        step(); step();
        abort2 = 1'b1; push2 = 1'b1; letter2 = 3'd4;
        step();
        abort2 = 1'b0; push2 = 1'b0;
        check("abort_mark",  int'(mark2), 0);
        check("abort_ledr",  int'(ledr2), 0);
        check("abort_busy",  int'(busy2), 0);
        check("abort_count", int'(count2), 0);
        check("abort_done",  int'(done2), 0);
        repeat (20) step();
        rec = 1'b0;
        check("abort_after_count", int'(count2), 0);
        check("abort_after_busy",  int'(busy2), 0);
        analyze();
        exp_m = '{3}; exp_l = '{4'b1000}; exp_s = '{1};
        cmp_trace("ABORT");
        check("ABORT_done", n_done, 0);

        // asynchronous reset during the first SPACE of D, then replay D
        letter1 = 3'd3; push1 = 1'b1;
        step();
        push1 = 1'b0;
        k = 0;
        while (mark1 !== 1'b1 && k < 20) begin step(); k++; end
        check("rst_mid_mark_up", int'(mark1), 1);
        k = 0;
        while (mark1 !== 1'b0 && k < 20) begin step(); k++; end
        check("rst_mid_in_space", int'(busy1), 1);
        #2;
        rst1 = 1'b1;
        #1;
        check("arst_mark",  int'(mark1), 0);
        check("arst_ledr",  int'(ledr1), 0);
        check("arst_busy",  int'(busy1), 0);
        check("arst_done",  int'(done1), 0);
        check("arst_count", int'(count1), 0);
        check("arst_ready", int'(ready1), 1);
        #1;
        rst1 = 1'b0;
        step();
        start_rec(1'b1);
        letter1 = 3'd3; push1 = 1'b1;
        step();
        push1 = 1'b0;
        repeat (20) step();
        rec = 1'b0;
        analyze();
        exp_m = '{3, 1, 1}; exp_l = '{4'b1000, 4'b0100, 4'b0010}; exp_s = '{1, 1, 1, 3};
        cmp_trace("D");
        check("D_done", n_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
